// File: rtl/dmi_target.sv
// Core-side DMI responder: one request at a time, fixed access latency,
// small debug register set gated by the password-unlock status.
module dmi_target #(
  parameter int unsigned AccessLatency = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [40:0] dmi_req_i,        // {addr[6:0], op[1:0], data[31:0]}
  input  logic        dmi_req_valid_i,
  output logic        dmi_req_ready_o,
  output logic [33:0] dmi_resp_o,       // {data[31:0], resp[1:0]}
  output logic        dmi_resp_valid_o,
  input  logic        dmi_resp_ready_i,
  input  logic        unlock_i,
  input  logic        halted_i,
  input  logic        resumeack_i,
  output logic        dmactive_o,
  output logic        ndmreset_o,
  output logic        haltreq_o,
  output logic        resumereq_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  localparam logic [3:0] LAT = AccessLatency[3:0];

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [40:0] r_req;
  logic [33:0] r_resp;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_data0, r_data1;
  logic        r_haltreq, r_ndmreset, r_dmactive;
  logic        r_resume_pend, r_resumeack_sticky;

  logic [40:0] w_req;
  logic [6:0]  w_addr;
  logic [1:0]  w_op;
  logic [31:0] w_wdata;
  logic        w_accept, w_exec, w_protected, w_deny, w_wr, w_ack_vis;
  logic [31:0] w_rdata;
  logic [33:0] w_resp;

  assign w_accept = (r_state == S_IDLE) && r_req_ready && dmi_req_valid_i;
  // With zero latency the access executes straight from the bus in the accept cycle
  assign w_req    = (r_state == S_IDLE) ? dmi_req_i : r_req;
  assign w_addr   = w_req[40:34];
  assign w_op     = w_req[33:32];
  assign w_wdata  = w_req[31:0];
  assign w_exec   = (w_accept && (LAT == 4'd0)) || ((r_state == S_BUSY) && (r_cnt == 4'd1));

  assign w_protected = (w_addr == 7'h04) || (w_addr == 7'h05) || (w_addr == 7'h10);
  assign w_deny      = !unlock_i && ((w_op == 2'd2) || ((w_op == 2'd1) && w_protected));
  assign w_wr        = w_exec && (w_op == 2'd2) && !w_deny;
  assign w_ack_vis   = r_resume_pend ? 1'b0 : r_resumeack_sticky;

  always_comb begin
    w_rdata = 32'h0;
    case (w_addr)
      7'h04:   w_rdata = r_data0;
      7'h05:   w_rdata = r_data1;
      7'h10:   w_rdata = {r_haltreq, 1'b0, 28'h0, r_ndmreset, r_dmactive};
      7'h11:   w_rdata = {14'h0, {2{w_ack_vis}}, 6'h0, {2{halted_i}}, unlock_i, 3'h0, 4'd2};
      default: w_rdata = 32'h0;
    endcase
  end

  always_comb begin
    w_resp = 34'h0;
    case (w_op)
      2'd1:    w_resp = w_deny ? {32'h0, 2'd2} : {w_rdata, 2'd0};
      2'd2:    w_resp = w_deny ? {32'h0, 2'd2} : {w_wdata, 2'd0};
      2'd3:    w_resp = {32'h0, 2'd2};
      default: w_resp = 34'h0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_req        <= 41'h0;
      r_resp       <= 34'h0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req       <= dmi_req_i;
            r_req_ready <= 1'b0;
            if (LAT == 4'd0) begin
              r_resp       <= w_resp;
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end else begin
              r_cnt   <= LAT;
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_resp       <= w_resp;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (dmi_resp_ready_i) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data0            <= 32'h0;
      r_data1            <= 32'h0;
      r_haltreq          <= 1'b0;
      r_ndmreset         <= 1'b0;
      r_dmactive         <= 1'b0;
      r_resume_pend      <= 1'b0;
      r_resumeack_sticky <= 1'b0;
    end else begin
      if (r_resume_pend && resumeack_i) begin
        r_resume_pend      <= 1'b0;
        r_resumeack_sticky <= 1'b1;
      end
      // Writes come last so a resume set beats a same-cycle ack
      if (w_wr) begin
        case (w_addr)
          7'h04: r_data0 <= w_wdata;
          7'h05: r_data1 <= w_wdata;
          7'h10: begin
            r_dmactive <= w_wdata[0];
            if (!w_wdata[0]) begin
              r_haltreq          <= 1'b0;
              r_ndmreset         <= 1'b0;
              r_resume_pend      <= 1'b0;
              r_resumeack_sticky <= 1'b0;
              r_data0            <= 32'h0;
              r_data1            <= 32'h0;
            end else begin
              r_haltreq  <= w_wdata[31];
              r_ndmreset <= w_wdata[1];
              if (w_wdata[30]) begin
                r_resume_pend      <= 1'b1;
                r_resumeack_sticky <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign dmi_req_ready_o  = r_req_ready;
  assign dmi_resp_o       = r_resp;
  assign dmi_resp_valid_o = r_resp_valid;
  assign dmactive_o       = r_dmactive;
  assign ndmreset_o       = r_ndmreset;
  assign haltreq_o        = r_haltreq;
  assign resumereq_o      = r_resume_pend;

endmodule

// File: tb/tb_dmi_target.sv
// Self-checking bench for dmi_target: directed scenarios plus randomized
// transactions compared against a register-level reference model.
module tb_dmi_target;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [40:0] req;
  logic        req_valid, req_ready;
  logic [33:0] resp;
  logic        resp_valid, resp_ready;
  logic        unlock, halted, resumeack;
  logic        dmactive, ndmreset, haltreq, resumereq;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_data0, m_data1;
  logic        m_haltreq, m_ndm, m_dmact, m_pend, m_sticky;

  dmi_target #(.AccessLatency(LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .dmi_req_i(req), .dmi_req_valid_i(req_valid), .dmi_req_ready_o(req_ready),
    .dmi_resp_o(resp), .dmi_resp_valid_o(resp_valid), .dmi_resp_ready_i(resp_ready),
    .unlock_i(unlock), .halted_i(halted), .resumeack_i(resumeack),
    .dmactive_o(dmactive), .ndmreset_o(ndmreset), .haltreq_o(haltreq), .resumereq_o(resumereq)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_data0 = 0; m_data1 = 0; m_haltreq = 0; m_ndm = 0; m_dmact = 0; m_pend = 0; m_sticky = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [6:0] a);
    logic [31:0] v;
    v = 0;
    if (a == 7'h04) v = m_data0;
    else if (a == 7'h05) v = m_data1;
    else if (a == 7'h10) v = (m_haltreq ? 32'h8000_0000 : 0) + (m_ndm ? 2 : 0) + (m_dmact ? 1 : 0);
    else if (a == 7'h11) v = ((!m_pend && m_sticky) ? 32'h0003_0000 : 0) + (halted ? 32'h300 : 0)
                             + (unlock ? 32'h80 : 0) + 2;
    return v;
  endfunction

  function automatic logic [33:0] model_exec(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d);
    bit prot;
    prot = (a == 7'h04) || (a == 7'h05) || (a == 7'h10);
    if (op == 0) return 34'h0;
    if (op == 3) return {32'h0, 2'd2};
    if (op == 1) begin
      if (!unlock && prot) return {32'h0, 2'd2};
      return {model_read(a), 2'd0};
    end
    if (!unlock) return {32'h0, 2'd2};
    if (a == 7'h04) m_data0 = d;
    if (a == 7'h05) m_data1 = d;
    if (a == 7'h10) begin
      m_dmact = d[0];
      if (!d[0]) begin
        m_haltreq = 0; m_ndm = 0; m_pend = 0; m_sticky = 0; m_data0 = 0; m_data1 = 0;
      end else begin
        m_haltreq = d[31]; m_ndm = d[1];
        if (d[30]) begin m_pend = 1; m_sticky = 0; end
      end
    end
    return {d, 2'd0};
  endfunction

  // Runs one full transaction; lat = clock edges from accept edge to response valid.
  task automatic do_txn(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d,
                        output logic [33:0] rsp, output int lat);
    int n;
    @(negedge clk);
    req = {a, op, d};
    req_valid = 1;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL accept_timeout: ready stayed %b, required 1", req_ready);
      req_valid = 0; rsp = '0; lat = 0;
      return;
    end
    lat = 0;
    do begin
      @(negedge clk);
      req_valid = 0;
      lat++;
    end while (!resp_valid && lat < 100);
    if (!resp_valid) begin
      checks++; errors++;
      $display("FAIL resp_timeout: resp_valid %b after %0d cycles, required 1", resp_valid, lat);
    end
    rsp = resp;
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp, dmactive, ndmreset, haltreq, resumereq} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b valid=%b resp=%h ctl=%b%b%b%b, required all 0",
               req_ready, resp_valid, resp, dmactive, ndmreset, haltreq, resumereq);
    end
    rst_n = 1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b required 0", req_ready); end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release: got %b required 1", req_ready); end
    model_reset();
  endtask

  task automatic test_data_rw();
    logic [33:0] r, e;
    int lat;
    unlock = 1;
    e = model_exec(7'h04, 2'd2, 32'hDEADBEEF);
    do_txn(7'h04, 2'd2, 32'hDEADBEEF, r, lat);
    checks++;
    if (r !== {32'hDEADBEEF, 2'd0} || e !== r) begin errors++; $display("FAIL write_data0: got %h required %h", r, {32'hDEADBEEF, 2'd0}); end
    checks++;
    if (lat != 1 + LAT) begin errors++; $display("FAIL write_latency: got %0d required %0d", lat, 1 + LAT); end
    do_txn(7'h04, 2'd1, 32'h0, r, lat);
    checks++;
    if (r !== {32'hDEADBEEF, 2'd0}) begin errors++; $display("FAIL read_data0: got %h required %h", r, {32'hDEADBEEF, 2'd0}); end
    checks++;
    if (lat != 1 + LAT) begin errors++; $display("FAIL read_latency: got %0d required %0d", lat, 1 + LAT); end
  endtask

  task automatic test_lock();
    logic [33:0] r, e;
    int lat;
    unlock = 0;
    e = model_exec(7'h05, 2'd2, 32'h1234);
    do_txn(7'h05, 2'd2, 32'h1234, r, lat);
    checks++;
    if (r !== e || r !== {32'h0, 2'd2}) begin errors++; $display("FAIL locked_write: got %h required %h", r, {32'h0, 2'd2}); end
    e = model_exec(7'h11, 2'd1, 0);
    do_txn(7'h11, 2'd1, 32'h0, r, lat);
    checks++;
    if (r !== e || r !== {32'h2, 2'd0}) begin errors++; $display("FAIL locked_dmstatus: got %h required %h", r, {32'h2, 2'd0}); end
    e = model_exec(7'h04, 2'd1, 0);
    do_txn(7'h04, 2'd1, 32'h0, r, lat);
    checks++;
    if (r !== {32'h0, 2'd2}) begin errors++; $display("FAIL locked_read_data0: got %h required %h", r, {32'h0, 2'd2}); end
    unlock = 1;
    e = model_exec(7'h11, 2'd1, 0);
    do_txn(7'h11, 2'd1, 32'h0, r, lat);
    checks++;
    if (r !== e || r !== {32'h82, 2'd0}) begin errors++; $display("FAIL unlocked_dmstatus: got %h required %h", r, {32'h82, 2'd0}); end
    e = model_exec(7'h05, 2'd1, 0);
    do_txn(7'h05, 2'd1, 32'h0, r, lat);
    checks++;
    if (r !== {32'h0, 2'd0}) begin errors++; $display("FAIL data1_unchanged: got %h required %h", r, {32'h0, 2'd0}); end
  endtask

  task automatic test_resume();
    logic [33:0] r, e;
    int lat;
    unlock = 1;
    e = model_exec(7'h10, 2'd2, 32'hC000_0001);
    do_txn(7'h10, 2'd2, 32'hC000_0001, r, lat);
    checks++;
    if ({haltreq, resumereq, dmactive} !== 3'b111) begin errors++; $display("FAIL resume_set: got halt/res/act=%b%b%b required 111", haltreq, resumereq, dmactive); end
    resumeack = 1;
    @(negedge clk);
    resumeack = 0;
    if (m_pend) begin m_pend = 0; m_sticky = 1; end
    checks++;
    if (resumereq !== 1'b0) begin errors++; $display("FAIL resume_ack_clear: got %b required 0", resumereq); end
    e = model_exec(7'h11, 2'd1, 0);
    do_txn(7'h11, 2'd1, 32'h0, r, lat);
    checks++;
    if (r[19:18] !== 2'b11 || r !== e) begin errors++; $display("FAIL dmstatus_ack: got %h required %h", r, e); end
  endtask

  task automatic test_dmactive_clear();
    logic [33:0] r, e;
    int lat;
    unlock = 1;
    e = model_exec(7'h04, 2'd2, 32'hFF);
    do_txn(7'h04, 2'd2, 32'hFF, r, lat);
    e = model_exec(7'h10, 2'd2, 32'h8000_0001);
    do_txn(7'h10, 2'd2, 32'h8000_0001, r, lat);
    checks++;
    if (haltreq !== 1'b1) begin errors++; $display("FAIL haltreq_set: got %b required 1", haltreq); end
    e = model_exec(7'h10, 2'd2, 32'h0);
    do_txn(7'h10, 2'd2, 32'h0, r, lat);
    checks++;
    if ({haltreq, dmactive, ndmreset, resumereq} !== 4'b0) begin errors++; $display("FAIL dmactive_clear_ctl: got %b%b%b%b required 0000", haltreq, dmactive, ndmreset, resumereq); end
    e = model_exec(7'h04, 2'd1, 0);
    do_txn(7'h04, 2'd1, 32'h0, r, lat);
    checks++;
    if (r !== {32'h0, 2'd0} || r !== e) begin errors++; $display("FAIL data0_cleared: got %h required %h", r, {32'h0, 2'd0}); end
  endtask

  task automatic test_back_to_back();
    logic [33:0] first, e;
    int n;
    bit stable_ok;
    unlock = 1;
    @(negedge clk);
    req = {7'h05, 2'd2, 32'h0000_0055};
    req_valid = 1;
    e = model_exec(7'h05, 2'd2, 32'h55);
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    req = {7'h05, 2'd1, 32'h0};
    n = 0;
    while (!resp_valid && n < 100) begin @(negedge clk); n++; end
    first = resp;
    checks++;
    if (first !== e) begin errors++; $display("FAIL bp_first_resp: got %h required %h", first, e); end
    stable_ok = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp !== first || req_ready !== 1'b0 || resp_valid !== 1'b1) begin
        stable_ok = 0;
        $display("FAIL bp_hold: cycle %0d resp=%h ready=%b valid=%b required resp=%h ready=0 valid=1",
                 i, resp, req_ready, resp_valid, first);
      end
    end
    checks++;
    if (!stable_ok) errors++;
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL bp_after_hs: ready=%b valid=%b required ready=1 valid=0", req_ready, resp_valid); end
    @(negedge clk);
    req_valid = 0;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept: ready=%b required 0 (accepted)", req_ready); end
    e = model_exec(7'h05, 2'd1, 0);
    n = 1;
    while (!resp_valid && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n != 1 + LAT || resp !== e) begin errors++; $display("FAIL bp_second_resp: got %h lat %0d required %h lat %0d", resp, n, e, 1 + LAT); end
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
  endtask

  task automatic test_random();
    logic [33:0] r, e;
    logic [6:0]  a;
    logic [1:0]  op;
    logic [31:0] d;
    logic [6:0]  amap[4];
    int lat;
    amap[0] = 7'h04; amap[1] = 7'h05; amap[2] = 7'h10; amap[3] = 7'h11;
    for (int i = 0; i < 60; i++) begin
      int k;
      k = $urandom_range(0, 4);
      a = (k == 4) ? 7'($urandom_range(0, 127)) : amap[k];
      op = 2'($urandom_range(0, 3));
      d = $urandom;
      unlock = ($urandom_range(0, 3) != 0);
      halted = 1'($urandom_range(0, 1));
      e = model_exec(a, op, d);
      do_txn(a, op, d, r, lat);
      checks++;
      if (r !== e) begin errors++; $display("FAIL rand_resp[%0d]: a=%h op=%0d got %h required %h", i, a, op, r, e); end
      checks++;
      if (lat != 1 + LAT) begin errors++; $display("FAIL rand_lat[%0d]: got %0d required %0d", i, lat, 1 + LAT); end
      checks++;
      if ({haltreq, ndmreset, dmactive, resumereq} !== {m_haltreq, m_ndm, m_dmact, m_pend}) begin
        errors++;
        $display("FAIL rand_ctl[%0d]: got %b required %b", i, {haltreq, ndmreset, dmactive, resumereq},
                 {m_haltreq, m_ndm, m_dmact, m_pend});
      end
    end
    halted = 0;
  endtask

  task automatic test_reset_mid();
    logic [33:0] r, e;
    int lat;
    bit quiet;
    unlock = 1;
    e = model_exec(7'h04, 2'd2, 32'hA5A5_0001);
    do_txn(7'h04, 2'd2, 32'hA5A5_0001, r, lat);
    e = model_exec(7'h10, 2'd2, 32'h8000_0003);
    do_txn(7'h10, 2'd2, 32'h8000_0003, r, lat);
    @(negedge clk);
    req = {7'h04, 2'd1, 32'h0};
    req_valid = 1;
    @(negedge clk);
    req_valid = 0;
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp, dmactive, ndmreset, haltreq, resumereq} !== '0) begin
      errors++;
      $display("FAIL reset_mid: ready=%b valid=%b resp=%h ctl=%b%b%b%b required all 0",
               req_ready, resp_valid, resp, dmactive, ndmreset, haltreq, resumereq);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    quiet = 1;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) quiet = 0;
    end
    checks++;
    if (!quiet) begin errors++; $display("FAIL reset_mid_no_resp: resp_valid rose after release, required 0"); end
    e = model_exec(7'h04, 2'd1, 0);
    do_txn(7'h04, 2'd1, 32'h0, r, lat);
    checks++;
    if (r !== e) begin errors++; $display("FAIL reset_mid_data0: got %h required %h", r, e); end
  endtask

  initial begin
    rst_n = 0; req = '0; req_valid = 0; resp_ready = 0;
    unlock = 0; halted = 0; resumeack = 0;
    model_reset();
    test_reset();
    test_data_rw();
    test_lock();
    test_resume();
    test_dmactive_clear();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmi_target.md
# dmi_target

Core-clock DMI responder that terminates the debug module interface opposite the JTAG DTM. It accepts one `dm::dmi_req_t` at a time over a valid/ready handshake, executes it against a small debug register set, and returns a `dm::dmi_resp_t` over a second valid/ready handshake. Register access is gated by the JTAG password-unlock status. It sits on the core side of the DMI CDC, in place of the full debug module, for bring-up and for lock verification.

## Interface
- `AccessLatency`, default 1: wait cycles between request accept and response valid; legal range 0..15.
- `clk_i` input 1: core clock.
- `rst_ni` input 1: asynchronous active-low reset.
- `dmi_req_i` input `dm::dmi_req_t`: request fields {addr[6:0], op[1:0], data[31:0]}.
- `dmi_req_valid_i` input 1: request valid.
- `dmi_req_ready_o` output 1: responder can accept a request.
- `dmi_resp_o` output `dm::dmi_resp_t`: response fields {data[31:0], resp[1:0]}.
- `dmi_resp_valid_o` output 1: response valid.
- `dmi_resp_ready_i` input 1: consumer accepts the response.
- `unlock_i` input 1: password check passed; level.
- `halted_i` input 1: hart halted status.
- `resumeack_i` input 1: hart acknowledged resume.
- `dmactive_o`, `ndmreset_o`, `haltreq_o`, `resumereq_o` output 1 each: debug control outputs.

## Operation
- The FSM has three states. Idle drives `dmi_req_ready_o`=1. Busy counts down the wait cycles. Resp drives `dmi_resp_valid_o`=1.
- **Idle:** on valid&&ready, latch the request. If AccessLatency=0, go to Resp; otherwise load the counter with AccessLatency and go to Busy.
- **Busy:** decrement the counter. When the counter reaches 1, execute the access and go to Resp.
- **Execution with AccessLatency=0:** the access executes in the accept cycle.
- **Resp:** hold `dmi_resp_o` stable until `dmi_resp_ready_i`=1, then go to Idle.
- **Register map:**
  - 0x04 data0 and 0x05 data1: RW, 32 bits.
  - 0x10 dmcontrol: bit31 haltreq RW; bit30 resumereq, write-1-to-set, reads 0; bit1 ndmreset RW; bit0 dmactive RW.
  - 0x11 dmstatus RO: bit17 and bit16 = resumereq pending ? 0 : resumeack sticky; bit9 and bit8 = `halted_i`; bit7 = `unlock_i`; bits3:0 = 2; all other bits 0.
  - Any other address: reads return 0, writes are ignored, resp=0.
- **Operation codes:**
  - op 0 (NOP): data 0, resp 0.
  - op 1 (read): data = register value.
  - op 2 (write): update the register; response data = written value.
  - op 3: no effect, data 0, resp 2.
- **Lock:** while `unlock_i`=0, any write, and any read of data0, data1 or dmcontrol, returns data 0, resp 2 and changes no state. A dmstatus read always succeeds. `unlock_i` is sampled at execution time.
- **dmactive:** a write with bit0=0 clears haltreq, ndmreset, the resumereq pending flag, the resumeack sticky bit, data0 and data1 in the same cycle. A write with dmactive=0 ignores the haltreq, resumereq and ndmreset bits.
- **resumereq:** the pending flag sets on a permitted dmcontrol write with bit30=1 and bit0=1; that write also clears the resumeack sticky bit. The flag clears on the first cycle with `resumeack_i`=1, and that cycle sets the resumeack sticky bit. If a set and an ack land in the same cycle, set wins. `resumereq_o` = pending flag.
- **Busy error:** resp=3 is never generated; backpressure is expressed only through ready.

## Timing
- **Reset values:** all outputs 0, state Idle, all registers 0. `dmi_req_ready_o` goes to 1 on the first clock after reset release.
- **Request-to-response latency:** 1+AccessLatency cycles from the accept edge to the first cycle with `dmi_resp_valid_o`=1.
- **Ready outside Idle:** `dmi_req_ready_o`=0 in Busy and Resp. A request presented there stalls and is not dropped.
- **Back-to-back:** a response handshake and a new request accept cannot occur in the same cycle. Minimum issue interval is 2+AccessLatency cycles.
- **Register outputs:** control outputs are registered and change the cycle after execution.
- **Stability:** `dmi_resp_o` is constant throughout Resp.
- **Reset mid-transaction:** asynchronous reset aborts any state, discards the pending response and clears all outputs immediately.

## Test plan
- Reset, unlock=1, write data0=0xDEADBEEF, then read data0 -> first response data 0xDEADBEEF resp 0; read response 0xDEADBEEF resp 0; each response exactly 2 cycles after accept (AccessLatency=1).
- unlock=0, write data1=0x1234, then read dmstatus -> write gets resp 2, data1 stays 0; dmstatus returns 0x00000002 (bit7=0); with unlock=1 the same read returns 0x00000082.
- unlock=1, write dmcontrol=0xC0000001 -> haltreq_o=1, resumereq_o=1. Pulse resumeack_i -> resumereq_o=0 next cycle, dmstatus bits17:16=11.
- Write dmcontrol=0x0 while data0=0xFF and haltreq_o=1 -> data0 reads 0, haltreq_o=0, dmactive_o=0.
- Hold dmi_resp_ready_i=0 for 10 cycles with a second request pending -> dmi_resp_o stable, dmi_req_ready_o=0; second request accepted the cycle after resp handshake.
- Assert rst_ni=0 during Busy -> all outputs 0 immediately; no response issued after release.
